// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - Shared register bit positions, FSM encodings and helpers for buffered_uart
package uart_defs;

  localparam int ST_TX_BUSY   = 0;
  localparam int ST_RX_AVAIL  = 1;
  localparam int ST_TX_FULL   = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_RX_IRQ_EN = 6;
  localparam int ST_TX_IRQ_EN = 7;
  localparam int ST_DIV_LSB   = 16;

  localparam int CTL_CLR_OVERRUN   = 4;
  localparam int CTL_CLR_FRAME_ERR = 5;
  localparam int CTL_RX_IRQ_EN     = 6;
  localparam int CTL_TX_IRQ_EN     = 7;
  localparam int CTL_DIV_LOAD      = 8;
  localparam int CTL_DIV_LSB       = 16;

  localparam int DIV_MIN = 3;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Very small divisors leave no room for the mid-bit sample point.
  function automatic logic [15:0] clamp_divisor(input logic [15:0] d);
    return (d < 16'(DIV_MIN)) ? 16'(DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - Power-of-two synchronous FIFO with show-ahead head output
module uart_fifo
  import uart_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/buffered_uart.sv
// rtl/buffered_uart.sv - Buffered 8N1 UART with TX/RX FIFOs, status/control register and irq
module buffered_uart
  import uart_defs::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic        reg_state_we,
  input  logic        reg_state_re,
  input  logic [31:0] reg_state_di,
  output logic [31:0] reg_state_do,
  output logic        reg_state_wait,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait,
  output logic        irq
);

  localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD_RATE - 1);

  logic [15:0] divisor;
  logic        rx_irq_en;
  logic        tx_irq_en;
  logic        overrun;
  logic        frame_err;
  logic        overrun_set;
  logic        frame_err_set;

  logic        tx_push;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic [7:0]  tx_head;
  logic [1:0]  tx_state;
  logic [15:0] tx_div;
  logic [15:0] tx_cnt;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;
  logic        tx_busy;

  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic        rx_push;
  logic        rx_full;
  logic        rx_empty;
  logic [7:0]  rx_head;
  logic [1:0]  rx_state;
  logic [15:0] rx_div;
  logic [15:0] rx_cnt;
  logic [16:0] div_plus1;
  logic [15:0] rx_half;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic        rx_bad;
  logic        rx_stop_sample;

  logic        unused_inputs;
  assign unused_inputs = ^{reg_state_re, reg_dat_di[31:8], reg_state_di[15:9], reg_state_di[3:0]};

  assign reg_state_wait = 1'b0;
  assign reg_dat_wait   = reg_dat_we && tx_full;
  assign reg_dat_do     = rx_empty ? 32'h0 : {24'h0, rx_head};

  assign tx_busy = !tx_empty || (tx_state != TX_IDLE);

  always_comb begin
    reg_state_do                       = '0;
    reg_state_do[ST_TX_BUSY]           = tx_busy;
    reg_state_do[ST_RX_AVAIL]          = !rx_empty;
    reg_state_do[ST_TX_FULL]           = tx_full;
    reg_state_do[ST_RX_FULL]           = rx_full;
    reg_state_do[ST_OVERRUN]           = overrun;
    reg_state_do[ST_FRAME_ERR]         = frame_err;
    reg_state_do[ST_RX_IRQ_EN]         = rx_irq_en;
    reg_state_do[ST_TX_IRQ_EN]         = tx_irq_en;
    reg_state_do[ST_DIV_LSB +: 16]     = divisor;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      divisor   <= DIV_RESET;
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (reg_state_we) begin
        rx_irq_en <= reg_state_di[CTL_RX_IRQ_EN];
        tx_irq_en <= reg_state_di[CTL_TX_IRQ_EN];
        if (reg_state_di[CTL_DIV_LOAD])
          divisor <= clamp_divisor(reg_state_di[CTL_DIV_LSB +: 16]);
      end
      overrun   <= (overrun & ~(reg_state_we & reg_state_di[CTL_CLR_OVERRUN])) | overrun_set;
      frame_err <= (frame_err & ~(reg_state_we & reg_state_di[CTL_CLR_FRAME_ERR])) | frame_err_set;
      irq <= (rx_irq_en & (!rx_empty | overrun | frame_err)) |
             (tx_irq_en & tx_empty & (tx_state == TX_IDLE));
    end
  end

  assign tx_push = reg_dat_we && !tx_full;
  // Popping at the last stop-bit clock chains the next start bit with no idle gap.
  assign tx_pop  = !tx_empty &&
                   ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == '0)));

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (tx_push),
    .push_data (reg_dat_di[7:0]),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_head)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_div   <= '0;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      ser_tx   <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_shift <= tx_head;
      tx_div   <= divisor;
      tx_cnt   <= divisor;
      ser_tx   <= 1'b0;
    end else begin
      case (tx_state)
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= tx_div;
            tx_bit   <= '0;
            ser_tx   <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= tx_div;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              ser_tx   <= 1'b1;
            end else begin
              tx_shift <= tx_shift >> 1;
              ser_tx   <= tx_shift[1];
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) tx_state <= TX_IDLE;
          else              tx_cnt   <= tx_cnt - 16'd1;
        end
        default: ser_tx <= 1'b1;
      endcase
    end
  end

  assign div_plus1      = {1'b0, divisor} + 17'd1;
  assign rx_half        = div_plus1[16:1];
  assign rx_stop_sample = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_push        = rx_stop_sample && rx_s2 && !rx_bad;
  assign frame_err_set  = rx_stop_sample && !rx_s2 && !rx_bad;
  assign overrun_set    = rx_push && rx_full && !reg_dat_re;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (reg_dat_re),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  // rx_bad marks a failed stop bit; STOP is held until the line returns high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_div   <= '0;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
      rx_bad   <= 1'b0;
    end else begin
      rx_s1   <= ser_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          rx_bad <= 1'b0;
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_div   <= divisor;
            rx_cnt   <= rx_half - 16'd1;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_state <= RX_DATA;
              rx_cnt   <= rx_div;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= rx_div;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: begin
          if (rx_cnt != '0)  rx_cnt   <= rx_cnt - 16'd1;
          else if (rx_s2)    rx_state <= RX_IDLE;
          else               rx_bad   <= 1'b1;
        end
      endcase
    end
  end

endmodule
